// File: rtl/pulse_seq_pkg.sv
// Shared types and constants for the multi-channel pulse sequencer.
package pulse_seq_pkg;

  localparam int unsigned PULSE_SEQ_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    ACTIVE = 2'd2
  } ch_state_e;

endpackage

// File: rtl/pulse_channel.sv
// One delay/width pulse channel: latches its settings on trig, then runs IDLE -> DELAY -> ACTIVE.
// With PULSE_SEQ_RETRIGGER_EN defined, a trig on a busy channel restarts it instead of flagging overrun.
module pulse_channel
  import pulse_seq_pkg::*;
#(
  parameter int unsigned CNT_W = PULSE_SEQ_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic             enable,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] width,
  input  logic             overrun_clr,
  output logic             out,
  output logic             busy,
  output logic             overrun
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dly_q, dly_d;
  logic [CNT_W-1:0] wid_q, wid_d;
  logic             out_q, out_d;
  logic             ovr_q, ovr_d;
  logic             start;

  assign start = trig & enable;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    wid_d   = wid_q;
    out_d   = out_q;
    ovr_d   = overrun_clr ? 1'b0 : ovr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dly_d   = delay;
          wid_d   = width;
          cnt_d   = '0;
          state_d = DELAY;
        end
      end
      DELAY: begin
        if (cnt_q < dly_q) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d   = '0;
          out_d   = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cnt_q < wid_q) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d   = '0;
          out_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A trig on a busy channel overrides the normal progression above.
    if (state_q != IDLE && start) begin
`ifdef PULSE_SEQ_RETRIGGER_EN
      dly_d   = delay;
      wid_d   = width;
      cnt_d   = '0;
      out_d   = 1'b0;
      state_d = DELAY;
`else
      ovr_d   = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dly_q   <= '0;
      wid_q   <= '0;
      out_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      wid_q   <= wid_d;
      out_q   <= out_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out     = out_q;
  assign busy    = (state_q != IDLE);
  assign overrun = ovr_q;

endmodule

// File: rtl/multi_channel_pulse_sequencer.sv
// Sync source (internal square wave or synchronized external input), rising-edge trig, NUM_CH channels.
// Optional macro PULSE_SEQ_RETRIGGER_EN selects restart-on-trig instead of overrun flagging in each channel.
module multi_channel_pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = PULSE_SEQ_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CNT_W-1:0]        period,
  input  logic                    sync_sel,
  input  logic                    sync_ext,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic [NUM_CH*CNT_W-1:0] ch_delay,
  input  logic [NUM_CH*CNT_W-1:0] ch_width,
  input  logic                    overrun_clr,
  output logic                    sync_out,
  output logic [NUM_CH-1:0]       ch_out,
  output logic [NUM_CH-1:0]       ch_busy,
  output logic [NUM_CH-1:0]       ch_overrun
);

  logic [CNT_W-1:0] sync_cnt_q, sync_cnt_d;
  logic             sync_q, sync_d;
  logic             ext_meta_q, ext_meta_d;
  logic             ext_sync_q, ext_sync_d;
  logic             src_prev_q, src_prev_d;
  logic             src;
  logic             trig;

  always_comb begin
    sync_cnt_d = sync_cnt_q;
    sync_d     = sync_q;
    // Compare with < so lowering period below the count clears at once.
    if (sync_cnt_q < period) begin
      sync_cnt_d = sync_cnt_q + CNT_W'(1);
    end else begin
      sync_cnt_d = '0;
      sync_d     = ~sync_q;
    end
    ext_meta_d = sync_ext;
    ext_sync_d = ext_meta_q;
    src        = sync_sel ? sync_q : ext_sync_q;
    src_prev_d = src;
    trig       = src & ~src_prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_cnt_q <= '0;
      sync_q     <= 1'b0;
      ext_meta_q <= 1'b0;
      ext_sync_q <= 1'b0;
      src_prev_q <= 1'b0;
    end else begin
      sync_cnt_q <= sync_cnt_d;
      sync_q     <= sync_d;
      ext_meta_q <= ext_meta_d;
      ext_sync_q <= ext_sync_d;
      src_prev_q <= src_prev_d;
    end
  end

  assign sync_out = sync_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pulse_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .trig        (trig),
      .enable      (ch_enable[i]),
      .delay       (ch_delay[i*CNT_W +: CNT_W]),
      .width       (ch_width[i*CNT_W +: CNT_W]),
      .overrun_clr (overrun_clr),
      .out         (ch_out[i]),
      .busy        (ch_busy[i]),
      .overrun     (ch_overrun[i])
    );
  end

endmodule

// File: doc/multi_channel_pulse_sequencer.md
MULTI_CHANNEL_PULSE_SEQUENCER -- requirements
Module: multi_channel_pulse_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of independent pulse channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of all period, delay and width counters.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic is on posedge clk.
REQ-004 SHALL have port rst, input, 1, meaning reset; synchronous, active-high.
REQ-005 SHALL have port period, input, CNT_W, meaning internal sync half-period minus one.
REQ-006 SHALL have port sync_sel, input, 1, meaning 1 = internal sync, 0 = sync_ext.
REQ-007 SHALL have port sync_ext, input, 1, meaning asynchronous external sync.
REQ-008 SHALL have port ch_enable, input, NUM_CH, meaning per-channel arm.
REQ-009 SHALL have port ch_delay, input, NUM_CH*CNT_W, meaning per-channel delay; channel i is bits [i*CNT_W +: CNT_W].
REQ-010 SHALL have port ch_width, input, NUM_CH*CNT_W, meaning per-channel width; packed the same way as ch_delay.
REQ-011 SHALL have port overrun_clr, input, 1, meaning clear all sticky overrun flags.
REQ-012 SHALL have port sync_out, output, 1, meaning internal sync square wave.
REQ-013 SHALL have ports ch_out, ch_busy and ch_overrun, each output, NUM_CH, meaning pulse output, channel not IDLE, and sticky overrun flag respectively.

Function
REQ-014 SHALL generate the internal sync with a free-running counter.
- Counter increments while < period.
- Otherwise the counter clears and sync_out toggles.
- Half-period is therefore period+1 cycles.
- If period is lowered below the current count, the counter clears and sync_out toggles on the next cycle.
REQ-015 SHALL pass sync_ext through a 2-flop synchronizer before use.
REQ-016 SHALL form a one-cycle trigger, trig, on the rising edge of the selected source: selected source high now, low in the previous cycle.
REQ-017 SHALL, when sync_sel changes, permit at most one spurious trig and never a trig longer than one cycle.
REQ-018 SHALL implement one channel FSM per channel with states IDLE, DELAY and ACTIVE.
REQ-019 SHALL, in IDLE with trig && ch_enable[i]:
- latch ch_delay[i] and ch_width[i] into shadow registers;
- clear the counter;
- go to DELAY.
REQ-020 SHALL, in DELAY, increment the counter while < shadow delay; otherwise clear the counter, set ch_out[i]=1 and go to ACTIVE.
REQ-021 SHALL, in ACTIVE, increment the counter while < shadow width; otherwise clear the counter, set ch_out[i]=0 and go to IDLE.
REQ-022 SHALL time the channel pulse relative to the trig cycle c:
- ch_out[i] rises at cycle c+delay+2;
- ch_out[i] stays high exactly width+1 cycles.
REQ-023 SHALL use shadow delay and width only; live changes to ch_delay or ch_width mid-sequence do not affect the sequence in flight.
REQ-024 SHALL, when ch_enable[i] deasserts mid-sequence, let the current pulse complete; no new sequence starts.
REQ-025 SHALL drive ch_busy[i]=1 whenever the channel state is not IDLE.
REQ-026 SHALL, on trig while a channel is busy and enabled (without retrigger), set ch_overrun[i]=1; the sequence in flight continues unchanged.
REQ-027 SHALL clear all ch_overrun bits on overrun_clr; if overrun_clr and a new overrun occur in the same cycle, set wins.
REQ-028 SHALL keep counter arithmetic unsigned CNT_W with no wrap: delay or width = all-ones is legal and bounded.

Reset
REQ-029 SHALL, on rst, force:
- sync_out=0, ch_out=0, ch_busy=0, ch_overrun=0;
- all counters and synchronizer flops to 0;
- all FSMs to IDLE.
REQ-030 SHALL abort any sequence in flight when rst asserts mid-pulse, with ch_out low in the cycle after rst is sampled.

Configuration
REQ-031 SHALL support macro PULSE_SEQ_RETRIGGER_EN:
- Defined: trig on a busy, enabled channel re-latches the shadows, clears the counter, forces ch_out[i]=0 and enters DELAY; ch_overrun is never set.
- Undefined: behaviour is per REQ-026.

Structure
REQ-032 SHALL place the channel state enumeration (IDLE, DELAY, ACTIVE) and the default CNT_W constant in shared package pulse_seq_pkg.
REQ-033 SHALL implement each channel in sub-module pulse_channel, instantiated NUM_CH times by generate; sync generation and edge detection stay in the top.

Verification
REQ-034 SHALL cover internal timing: period=9 -> sync_out toggles every 10 cycles; ch0 delay=3, width=2 -> ch_out[0] rises 5 cycles after the sync_out rise and is high 3 cycles.
REQ-035 SHALL cover the external path: sync_sel=0, sync_ext rises at cycle x, ch1 delay=0, width=0 -> ch_out[1] is high only in cycle x+4.
REQ-036 SHALL cover overrun: period=2, ch0 delay=10 -> ch_overrun[0]=1 after the second sync edge; overrun_clr clears it; with PULSE_SEQ_RETRIGGER_EN the flag stays 0 and ch_out[0] never rises.
REQ-037 SHALL cover shadowing: change ch_delay[2] from 20 to 1 during DELAY -> rise still at c+22.
REQ-038 SHALL cover mid-operation reset: rst during ACTIVE -> all outputs 0 the next cycle; the next trig produces a normal pulse.
REQ-039 SHALL cover multi-channel: NUM_CH=4 with distinct delays 0, 5, 17, 100 -> all four pulses land on their exact cycles from a single trig.
